// File: rtl/hcpf_rd_arbiter_if.sv
// AXI4 read address / read data channel pair shared by the HCPF read-stage arbiter.
// The master modport is the arbiter side, the slave modport is the interconnect side.
interface hcpf_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 6
);
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [ID_W-1:0]   ar_id;
    logic              ar_ready;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [ID_W-1:0]   r_id;
    logic              r_ready;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_id,
        input  ar_ready,
        input  r_valid, r_data, r_last, r_id,
        output r_ready
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_id,
        output ar_ready,
        output r_valid, r_data, r_last, r_id,
        input  r_ready
    );
endinterface

// File: rtl/hcpf_rd_arbiter.sv
// Round-robin read arbiter for the HCPF FTL read stage.
// Each granted requester issues one AR burst tagged with its index in ar_id.
// R beats are steered back by r_id, and a per-requester outstanding cap is enforced.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | arbitrate among eligible requesters, pulse req_ready
// ST_ISSUE | hold the latched AR burst until ar_ready
module hcpf_rd_arbiter #(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 6,
    parameter int MAX_OUTS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*8-1:0]       req_len,
    output logic [N_REQ-1:0]         req_ready,
    hcpf_rd_arbiter_if.master        axi,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_last,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic                     id_err,
    output logic                     busy
);
    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic                       ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]          ar_addr_q, ar_addr_d;
    logic [7:0]                 ar_len_q, ar_len_d;
    logic [ID_W-1:0]            ar_id_q, ar_id_d;
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0][CW-1:0]   outs_q, outs_d;
    logic                       id_err_q, id_err_d;

    logic [N_REQ-1:0]           elig;
    logic                       grant_found;
    logic [PW-1:0]              grant_idx;
    logic [PW-1:0]              issued_idx;
    logic                       ar_hs;
    logic                       r_hs;
    logic                       r_id_legal;
    logic                       r_ready_sel;

    assign issued_idx = ar_id_q[PW-1:0];
    assign ar_hs      = ar_valid_q && axi.ar_ready;
    assign r_hs       = axi.r_valid && axi.r_ready;
    assign r_id_legal = (axi.r_id < ID_W'(N_REQ));

    // Eligibility and round-robin search starting at rr_ptr with wrap-around.
    always_comb begin : arb_comb
        int          cand;
        logic [PW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        elig        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (outs_q[i] < CW'(MAX_OUTS));
        end
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = PW'(cand);
            if (!grant_found && elig[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Accept pulse: only in IDLE, one-hot on the granted requester, silent in reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = !reset && (state_q == ST_IDLE) && grant_found &&
                           (grant_idx == PW'(i));
        end
    end

    // AR-side FSM: latch the granted burst, hold it until the handshake.
    always_comb begin
        state_d    = state_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_id_d    = ar_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant_idx == PW'(i)) begin
                            ar_addr_d = req_addr[i*ADDR_W +: ADDR_W];
                            ar_len_d  = req_len[i*8 +: 8];
                        end
                    end
                    ar_id_d    = ID_W'(grant_idx);
                    ar_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (axi.ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    rr_ptr_d   = (issued_idx == PW'(N_REQ - 1)) ? '0 : issued_idx + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // R steering: illegal IDs are always drained so the interconnect never stalls on them.
    always_comb begin
        r_ready_sel = 1'b1;
        rsp_valid   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (axi.r_id == ID_W'(i)) begin
                r_ready_sel = rsp_ready[i];
            end
            rsp_valid[i] = !reset && axi.r_valid && (axi.r_id == ID_W'(i));
        end
    end

    // Outstanding counters saturate at both ends; a last beat at zero flags an error.
    always_comb begin : outs_comb
        logic inc;
        logic dec;
        inc      = 1'b0;
        dec      = 1'b0;
        outs_d   = outs_q;
        id_err_d = id_err_q;
        if (axi.r_valid && !r_id_legal) begin
            id_err_d = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            inc = ar_hs && (ar_id_q == ID_W'(i));
            dec = r_hs && axi.r_last && (axi.r_id == ID_W'(i));
            if (inc && !dec) begin
                if (outs_q[i] != CW'(MAX_OUTS)) begin
                    outs_d[i] = outs_q[i] + 1'b1;
                end
            end else if (dec && !inc) begin
                if (outs_q[i] == '0) begin
                    id_err_d = 1'b1;
                end else begin
                    outs_d[i] = outs_q[i] - 1'b1;
                end
            end
        end
    end

    // State and tracking registers; reset drops all outstanding bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            rr_ptr_q   <= '0;
            outs_q     <= '0;
            id_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_id_q    <= ar_id_d;
            rr_ptr_q   <= rr_ptr_d;
            outs_q     <= outs_d;
            id_err_q   <= id_err_d;
        end
    end

    assign axi.ar_valid = ar_valid_q;
    assign axi.ar_addr  = ar_addr_q;
    assign axi.ar_len   = ar_len_q;
    assign axi.ar_size  = 3'd3;
    assign axi.ar_id    = ar_id_q;
    assign axi.r_ready  = !reset && r_ready_sel;

    assign rsp_data = axi.r_data;
    assign rsp_last = axi.r_last;
    assign id_err   = id_err_q;
    assign busy     = ar_valid_q || (|outs_q);
endmodule

// File: tb/tb_hcpf_rd_arbiter.sv
// Scoreboard bench for hcpf_rd_arbiter: expected AR bursts are queued as requests
// are driven and popped by a monitor on every AR handshake.
module tb_hcpf_rd_arbiter;
    localparam int N_REQ    = 3;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int ID_W     = 6;
    localparam int MAX_OUTS = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ADDR_W-1:0]  req_addr;
    logic [N_REQ*8-1:0]       req_len;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_last;
    logic [N_REQ-1:0]         rsp_ready;
    logic                     id_err;
    logic                     busy;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [ID_W-1:0]   id;
    } ar_exp_t;

    ar_exp_t exp_q[$];
    ar_exp_t mon_e;

    hcpf_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    hcpf_rd_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .axi       (axi.master),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_ready (rsp_ready),
        .id_err    (id_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_len[i*8 +: 8]            = l;
    endtask

    task automatic expect_ar(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] l);
        ar_exp_t e;
        e.addr = a;
        e.len  = l;
        e.id   = ID_W'(i);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid    = '0;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_last   = 1'b0;
        axi.r_id     = '0;
        rsp_ready    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic r_beat(input int id, input logic last);
        axi.r_valid = 1'b1;
        axi.r_id    = ID_W'(id);
        axi.r_last  = last;
        rsp_ready   = '1;
        tick();
        axi.r_valid = 1'b0;
        axi.r_last  = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("hs_timeout", 64'(hs_cnt >= target), 64'd1);
    endtask

    // AR monitor: every handshake must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && axi.ar_valid && axi.ar_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("ar_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ar_addr", axi.ar_addr, mon_e.addr);
                chk("ar_len",  axi.ar_len,  mon_e.len);
                chk("ar_id",   axi.ar_id,   mon_e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        axi.r_data   = 64'hDEAD_BEEF_0123_4567;
        req_addr     = '0;
        req_len      = '0;
        axi.ar_ready = 1'b0;
        axi.r_last   = 1'b0;

        // reset values, with request and R traffic present during reset
        reset       = 1'b1;
        req_valid   = '1;
        axi.r_valid = 1'b1;
        axi.r_id    = '0;
        rsp_ready   = '1;
        tick();
        tick();
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_ar_addr",  axi.ar_addr, 0);
        chk("rst_ar_len",   axi.ar_len, 0);
        chk("rst_ar_id",    axi.ar_id, 0);
        chk("rst_ar_size",  axi.ar_size, 3);
        chk("rst_busy",     busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_id_err",   id_err, 0);
        chk("rst_r_ready",  axi.r_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        axi.r_valid = 1'b0;
        req_valid   = '0;
        rsp_ready   = '0;
        tick();
        reset = 1'b0;
        tick();

        // single request from requester 1 with a 3-cycle AR stall
        base = hs_cnt;
        set_req(1, 32'h40, 8'd15);
        expect_ar(1, 32'h40, 8'd15);
        req_valid = 3'b010;
        #1;
        chk("single_req_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1;
        chk("single_ar_valid", axi.ar_valid, 1);
        chk("single_ar_addr",  axi.ar_addr, 32'h40);
        chk("single_ar_len",   axi.ar_len, 15);
        chk("single_ar_id",    axi.ar_id, 1);
        chk("single_ready_issue", req_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_ar_valid", axi.ar_valid, 1);
            chk("stall_ar_addr",  axi.ar_addr, 32'h40);
            chk("stall_ar_len",   axi.ar_len, 15);
            chk("stall_ar_id",    axi.ar_id, 1);
        end
        axi.ar_ready = 1'b1;
        wait_hs(base + 1, 5);
        axi.ar_ready = 1'b0;
        #1;
        chk("single_ar_valid_clr", axi.ar_valid, 0);
        chk("single_outs1", dut.outs_q[1], 1);
        chk("single_busy", busy, 1);
        axi.r_valid = 1'b1;
        axi.r_id    = 6'd1;
        axi.r_last  = 1'b1;
        rsp_ready   = '1;
        #1;
        chk("single_rsp_valid", rsp_valid, 3'b010);
        chk("single_rsp_data", rsp_data, 64'hDEAD_BEEF_0123_4567);
        chk("single_rsp_last", rsp_last, 1);
        tick();
        axi.r_valid = 1'b0;
        axi.r_last  = 1'b0;
        #1;
        chk("single_busy_done", busy, 0);
        chk("single_sb_empty", exp_q.size(), 0);

        // round-robin fairness with all requesters valid
        do_reset();
        base = hs_cnt;
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, ADDR_W'(32'h1000 * (i + 1)), 8'(i + 1));
        end
        for (int k = 0; k < 6; k++) begin
            expect_ar(k % 3, ADDR_W'(32'h1000 * ((k % 3) + 1)), 8'((k % 3) + 1));
        end
        req_valid    = '1;
        axi.ar_ready = 1'b1;
        wait_hs(base + 6, 40);
        req_valid    = '0;
        axi.ar_ready = 1'b0;
        #1;
        chk("rr_sb_empty", exp_q.size(), 0);
        for (int i = 0; i < N_REQ; i++) begin
            chk("rr_outs", dut.outs_q[i], 2);
        end
        for (int i = 0; i < N_REQ; i++) begin
            r_beat(i, 1'b1);
            r_beat(i, 1'b1);
        end
        #1;
        chk("rr_busy_done", busy, 0);

        // outstanding cap on requester 0
        do_reset();
        base = hs_cnt;
        set_req(0, 32'h200, 8'd3);
        for (int k = 0; k < MAX_OUTS; k++) begin
            expect_ar(0, 32'h200, 8'd3);
        end
        req_valid    = 3'b001;
        axi.ar_ready = 1'b1;
        repeat (20) tick();
        chk("cap_hs_count", 64'(hs_cnt - base), MAX_OUTS);
        chk("cap_req_ready", req_ready, 0);
        chk("cap_ar_valid", axi.ar_valid, 0);
        chk("cap_outs0", dut.outs_q[0], MAX_OUTS);
        expect_ar(0, 32'h200, 8'd3);
        axi.r_valid = 1'b1;
        axi.r_id    = '0;
        axi.r_last  = 1'b1;
        rsp_ready   = '1;
        tick();
        axi.r_valid = 1'b0;
        axi.r_last  = 1'b0;
        #1;
        chk("cap_reopen", req_ready, 3'b001);
        wait_hs(base + MAX_OUTS + 1, 10);
        req_valid    = '0;
        axi.ar_ready = 1'b0;
        #1;
        chk("cap_sb_empty", exp_q.size(), 0);
        repeat (MAX_OUTS) r_beat(0, 1'b1);
        #1;
        chk("cap_busy_done", busy, 0);

        // R steering and backpressure
        do_reset();
        base = hs_cnt;
        set_req(2, 32'h300, 8'd1);
        expect_ar(2, 32'h300, 8'd1);
        req_valid    = 3'b100;
        axi.ar_ready = 1'b1;
        wait_hs(base + 1, 10);
        req_valid    = '0;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b1;
        axi.r_id     = 6'd2;
        axi.r_last   = 1'b0;
        rsp_ready    = 3'b011;
        #1;
        chk("steer_rsp_valid", rsp_valid, 3'b100);
        chk("steer_r_ready_bp", axi.r_ready, 0);
        rsp_ready = 3'b111;
        #1;
        chk("steer_r_ready", axi.r_ready, 1);
        tick();
        chk("steer_outs_mid", dut.outs_q[2], 1);
        axi.r_last = 1'b1;
        tick();
        axi.r_valid = 1'b0;
        axi.r_last  = 1'b0;
        #1;
        chk("steer_outs_dec", dut.outs_q[2], 0);

        // simultaneous AR handshake and R last on requester 2
        expect_ar(2, 32'h300, 8'd1);
        req_valid    = 3'b100;
        axi.ar_ready = 1'b1;
        wait_hs(base + 2, 10);
        axi.ar_ready = 1'b0;
        expect_ar(2, 32'h300, 8'd1);
        tick();
        req_valid    = '0;
        axi.ar_ready = 1'b1;
        axi.r_valid  = 1'b1;
        axi.r_id     = 6'd2;
        axi.r_last   = 1'b1;
        rsp_ready    = '1;
        tick();
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_last   = 1'b0;
        #1;
        chk("sim_outs2", dut.outs_q[2], 1);
        chk("sim_sb_empty", exp_q.size(), 0);

        // illegal ID drained and sticky id_err
        do_reset();
        axi.r_valid = 1'b1;
        axi.r_id    = 6'd5;
        rsp_ready   = '0;
        #1;
        chk("illegal_r_ready", axi.r_ready, 1);
        chk("illegal_rsp_valid", rsp_valid, 0);
        chk("illegal_id_err_pre", id_err, 0);
        tick();
        axi.r_valid = 1'b0;
        repeat (3) tick();
        chk("illegal_id_err_sticky", id_err, 1);
        do_reset();
        chk("illegal_id_err_clr", id_err, 0);
        r_beat(0, 1'b1);
        #1;
        chk("spurious_id_err", id_err, 1);
        chk("spurious_outs0", dut.outs_q[0], 0);

        // reset in the middle of an issue with outstanding bursts
        do_reset();
        base = hs_cnt;
        set_req(1, 32'h500, 8'd2);
        set_req(2, 32'h600, 8'd4);
        expect_ar(1, 32'h500, 8'd2);
        expect_ar(2, 32'h600, 8'd4);
        expect_ar(1, 32'h500, 8'd2);
        req_valid    = 3'b110;
        axi.ar_ready = 1'b1;
        wait_hs(base + 3, 20);
        axi.ar_ready = 1'b0;
        set_req(0, 32'h700, 8'd7);
        req_valid = 3'b001;
        tick();
        chk("mid_ar_valid", axi.ar_valid, 1);
        chk("mid_outs1", dut.outs_q[1], 2);
        chk("mid_outs2", dut.outs_q[2], 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_ar_valid", axi.ar_valid, 0);
        chk("mid_rst_ar_addr", axi.ar_addr, 0);
        chk("mid_rst_ar_len", axi.ar_len, 0);
        chk("mid_rst_ar_id", axi.ar_id, 0);
        chk("mid_rst_ar_size", axi.ar_size, 3);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_outs", dut.outs_q, 0);
        tick();
        reset     = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("mid_first_grant", req_ready, 3'b001);
        req_valid = '0;
        tick();
        chk("end_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hcpf_rd_arbiter.md
# hcpf_rd_arbiter

Round-robin arbiter that shares the single AXI4 read-address/read-data channel pair of the HCPF FTL read stage among `N_REQ` internal read requesters. Each granted request is issued as one AR burst tagged with the requester index in `arid`. Returning R beats are steered back to the owning requester by `rid`. It sits between the read-stage request generators and the `io_RStageAxi_*` port of `HCPFTLModule`, and enforces a per-requester cap on outstanding bursts.

## Interface
Parameters:
- `N_REQ`, 3, number of requesters (2..8)
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 64, AXI data width
- `ID_W`, 6, AXI ID width (must be ≥ clog2(N_REQ))
- `MAX_OUTS`, 4, maximum outstanding bursts per requester (1..15)

Ports (clock and reset first):
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_addr`  in  N_REQ*ADDR_W  burst byte address. Requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_len`  in  N_REQ*8  AXI len (beats−1). Slice [i*8 +: 8].
- `req_ready`  out  N_REQ  one-hot accept pulse.
- `ar_valid`  out  1  AXI AR valid.
- `ar_addr`  out  ADDR_W  AXI AR address.
- `ar_len`  out  8  AXI AR len.
- `ar_size`  out  3  constant 3'd3 (8-byte beats).
- `ar_id`  out  ID_W  requester index, zero-extended.
- `ar_ready`  in  1  AXI AR ready.
- `r_valid`  in  1  AXI R valid.
- `r_data`  in  DATA_W  AXI R data.
- `r_last`  in  1  AXI R last.
- `r_id`  in  ID_W  AXI R ID.
- `r_ready`  out  1  AXI R ready.
- `rsp_valid`  out  N_REQ  steered R valid.
- `rsp_data`  out  DATA_W  equals `r_data` (shared).
- `rsp_last`  out  1  equals `r_last` (shared).
- `rsp_ready`  in  N_REQ  per-requester R ready.
- `id_err`  out  1  sticky flag: an R beat arrived with `r_id` ≥ N_REQ.
- `busy`  out  1  high while any outstanding count ≠ 0 or `ar_valid` is high.

## Operation
- The AR side is a 2-state FSM: IDLE and ISSUE.
- **IDLE**:
  - Eligible set: `req_valid[i]` && `outs[i]` < MAX_OUTS.
  - If the set is non-empty, grant the first eligible index searching upward from `rr_ptr`, with wrap-around.
  - Pulse `req_ready[g]` for one cycle (combinational in IDLE; gated by the grant).
  - Latch `req_addr`/`req_len` slice g into the AR registers, set `ar_id`=g, set `ar_valid`=1, and go to ISSUE.
- **ISSUE**:
  - Hold `ar_valid` and all AR fields stable until `ar_ready`.
  - On the handshake: clear `ar_valid`, increment `outs[g]`, set `rr_ptr`=(g+1) mod N_REQ, and return to IDLE.
  - `req_ready` is 0 throughout ISSUE.
- **Outstanding counters** `outs[i]` (width clog2(MAX_OUTS+1)):
  - +1 on an AR handshake with id i.
  - −1 on an R handshake with `r_last` and `r_id`=i.
  - Both in the same cycle: unchanged.
  - The counters never wrap. A decrement at 0 (spurious last) is ignored and sets `id_err`.
- **R steering** (purely combinational):
  - `rsp_valid[i]` = `r_valid` && `r_id`==i.
  - `r_ready` = `rsp_ready[r_id]` when `r_id` < N_REQ, otherwise 1, so illegal IDs are drained.
  - `rsp_data` = `r_data`; `rsp_last` = `r_last`.
- `id_err` is set by an illegal `r_id` or a spurious last, and is cleared only by `reset`.

## Timing
- Reset (async assert, synchronous-safe deassert): FSM=IDLE, `ar_valid`=0, `ar_addr`=0, `ar_len`=0, `ar_id`=0, all `outs`=0, `rr_ptr`=0, `id_err`=0, `busy`=0, `req_ready`=0.
- While reset is asserted, `r_ready` is 0 and `rsp_valid` is 0.
- Request accepted in cycle T (`req_valid[g]` && `req_ready[g]`) → `ar_valid`=1 from T+1.
- Minimum AR issue interval is 2 cycles (one IDLE cycle plus at least one ISSUE cycle).
- A requester whose `outs` has just reached MAX_OUTS is ineligible from the cycle after the AR handshake. A decrement in cycle T makes it eligible in T+1.
- R path latency is 0 cycles; there is no buffering.
- Reset asserted mid-burst drops all tracking. Bursts already in flight on the interconnect are not drained by this block.
- `ar_size` is constant 3'd3 in every cycle, including during reset.

## Test plan
- **Single request:** reset, then requester 1 with addr=0x40, len=15.
  - `req_ready[1]` pulses one cycle.
  - Next cycle: `ar_valid`=1, `ar_addr`=0x40, `ar_len`=15, `ar_id`=1.
  - Hold `ar_ready`=0 for 3 cycles: all fields stay stable.
  - After the handshake, `outs[1]`=1 and `busy`=1.
- **Round-robin fairness:** all 3 requesters valid continuously with MAX_OUTS=4, bursts returned promptly → `ar_id` sequence 0,1,2,0,1,2.
- **Outstanding cap:** requester 0 only, no R returned → exactly 4 AR handshakes, then `req_ready[0]` stays 0. Return one burst with `r_last` → the 5th request is accepted in the following cycle.
- **R steering and backpressure:**
  - `r_id`=2, `r_valid`=1, `rsp_ready[2]`=0 → `rsp_valid`=3'b100, `r_ready`=0.
  - Raise `rsp_ready[2]` → `r_ready`=1. On the last beat, `outs[2]` decrements.
  - Simultaneous AR handshake id 2 and R last id 2 → `outs[2]` is unchanged.
- **Illegal ID:** `r_id`=5 with `r_valid`=1 → `r_ready`=1, `rsp_valid`=0, and `id_err`=1 persisting until reset.
- **Reset mid-operation:** assert `reset` while `ar_valid`=1 and `outs`={1,2,0}. All outputs go to their reset values asynchronously, before the next edge. After release, requester 0 is granted first.
